// File: rtl/game_pkg.sv
// Shared 2048 game definitions: tile width, win value, board type,
// move/mux direction encoding and the board controller state encoding.
package game_pkg;

   localparam int TILE_W    = 12;
   localparam int WIN_VALUE = 2048;

   typedef logic [3:0][3:0][TILE_W-1:0] board_t;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_COMPARE,
      ST_SPAWN,
      ST_INIT_CLR
   } state_t;

endpackage

// File: rtl/board_move_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick tile spawn positions.
module lfsr16 #(
   parameter logic [15:0] RST_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= RST_SEED;
      else if (load)
         q <= seed;
      else
         q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   end

endmodule

// File: rtl/board_move_ctrl.sv
// Owner of the registered 2048 board: drives the move mux select, commits moved
// boards and spawns new tiles. Define BOARD_SPAWN_FOUR_EN to spawn 4s 1/8 of the time.
//
// state       | meaning
// ST_IDLE     | ready for a move request or new-game init
// ST_SETTLE   | sel just changed, mux/move path settling
// ST_COMPARE  | sample moved_board, commit if it differs
// ST_SPAWN    | scan from an LFSR-chosen cell for an empty slot
// ST_INIT_CLR | clear board and flags, reseed, then spawn two tiles
module board_move_ctrl #(
   parameter int          TILE_W    = game_pkg::TILE_W,
   parameter int          WIN_VALUE = game_pkg::WIN_VALUE,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         init,
   input  logic                         move_valid,
   input  logic [1:0]                   move_dir,
   output logic                         move_ready,
   output logic [1:0]                   sel,
   input  logic [3:0][3:0][TILE_W-1:0]  moved_board,
   output logic [3:0][3:0][TILE_W-1:0]  board,
   output logic                         busy,
   output logic                         changed,
   output logic                         won,
   output logic                         lost
);
   import game_pkg::*;

   localparam logic [TILE_W-1:0] L_WIN = TILE_W'(WIN_VALUE);

   state_t                        r_state;
   logic [1:0]                    r_sel;
   logic [3:0][3:0][TILE_W-1:0]   r_board;
   logic                          r_changed;
   logic                          r_won;
   logic                          r_lost;
   logic [1:0]                    r_spawn_left;
   logic [3:0]                    r_idx;
   logic [3:0]                    r_scan_cnt;

   logic [15:0]                   w_lfsr;
   logic                          w_lfsr_unused;
   logic                          w_has_zero;
   logic                          w_has_win;
   logic [TILE_W-1:0]             w_cell;
   logic [TILE_W-1:0]             w_spawn_val;

   lfsr16 #(.RST_SEED(LFSR_SEED)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (r_state == ST_INIT_CLR),
      .seed (LFSR_SEED),
      .q    (w_lfsr)
   );

   assign w_lfsr_unused = ^w_lfsr[15:4];

`ifdef BOARD_SPAWN_FOUR_EN
   assign w_spawn_val = (w_lfsr[6:4] == 3'b000) ? TILE_W'(4) : TILE_W'(2);
`else
   assign w_spawn_val = TILE_W'(2);
`endif

   always_comb begin
      w_has_zero = 1'b0;
      w_has_win  = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (r_board[r][c] == '0)    w_has_zero = 1'b1;
            if (r_board[r][c] == L_WIN) w_has_win  = 1'b1;
         end
      end
   end

   assign w_cell = r_board[r_idx[3:2]][r_idx[1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_sel        <= 2'd0;
         r_board      <= '0;
         r_changed    <= 1'b0;
         r_won        <= 1'b0;
         r_lost       <= 1'b0;
         r_spawn_left <= 2'd0;
         r_idx        <= 4'd0;
         r_scan_cnt   <= 4'd0;
      end else begin
         r_changed <= 1'b0;
         // INIT_CLR still sees the old board, so the clear must win over set
         if (r_state == ST_INIT_CLR)
            r_won <= 1'b0;
         else if (w_has_win)
            r_won <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (init) begin
                  r_state <= ST_INIT_CLR;
               end else if (move_valid) begin
                  r_sel   <= move_dir;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: r_state <= ST_COMPARE;
            ST_COMPARE: begin
               if (moved_board != r_board) begin
                  r_board      <= moved_board;
                  r_changed    <= 1'b1;
                  r_spawn_left <= 2'd1;
                  r_idx        <= w_lfsr[3:0];
                  r_scan_cnt   <= 4'd0;
                  r_state      <= ST_SPAWN;
               end else begin
                  if (!w_has_zero) r_lost <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_SPAWN: begin
               if (w_cell == '0) begin
                  r_board[r_idx[3:2]][r_idx[1:0]] <= w_spawn_val;
                  r_spawn_left <= r_spawn_left - 2'd1;
                  if (r_spawn_left == 2'd1) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_idx      <= w_lfsr[3:0];
                     r_scan_cnt <= 4'd0;
                  end
               end else begin
                  r_idx      <= r_idx + 4'd1;
                  r_scan_cnt <= r_scan_cnt + 4'd1;
                  if (r_scan_cnt == 4'd15) r_state <= ST_IDLE;
               end
            end
            ST_INIT_CLR: begin
               r_board      <= '0;
               r_lost       <= 1'b0;
               r_spawn_left <= 2'd2;
               r_idx        <= w_lfsr[3:0];
               r_scan_cnt   <= 4'd0;
               r_state      <= ST_SPAWN;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign move_ready = (r_state == ST_IDLE);
   assign busy       = (r_state != ST_IDLE);
   assign sel        = r_sel;
   assign board      = r_board;
   assign changed    = r_changed;
   assign won        = r_won;
   assign lost       = r_lost;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Directed bench for board_move_ctrl: table of move vectors plus hand-written
// init, busy and reset-during-spawn sequences, with a reference spawn model.
module tb_board_move_ctrl;
   import game_pkg::*;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst;
   logic       init;
   logic       move_valid;
   logic [1:0] move_dir;
   logic       move_ready;
   logic [1:0] sel;
   board_t     moved_board;
   board_t     board;
   logic       busy;
   logic       changed;
   logic       won;
   logic       lost;

   board_move_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .init        (init),
      .move_valid  (move_valid),
      .move_dir    (move_dir),
      .move_ready  (move_ready),
      .sel         (sel),
      .moved_board (moved_board),
      .board       (board),
      .busy        (busy),
      .changed     (changed),
      .won         (won),
      .lost        (lost)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference LFSR running in lockstep with the design's spawn LFSR
   logic [15:0] m_lfsr;
   logic        m_initclr;
   board_t      m_board;

   function automatic logic [15:0] lfsr_nx(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_lfsr    <= SEED;
         m_initclr <= 1'b0;
      end else begin
         m_initclr <= init;
         m_lfsr    <= m_initclr ? SEED : lfsr_nx(m_lfsr);
      end
   end

   function automatic board_t spawn_model(input board_t b_in, input logic [15:0] l_entry,
                                          input logic [15:0] l_first, input int n);
      board_t      b;
      logic [3:0]  idx;
      logic [15:0] lf;
      int          scan;
      int          left;
      b    = b_in;
      idx  = l_entry[3:0];
      lf   = l_first;
      scan = 0;
      left = n;
      for (int c = 0; c < 64; c++) begin
         if (b[idx[3:2]][idx[1:0]] == '0) begin
            b[idx[3:2]][idx[1:0]] = TILE_W'(2);
            left--;
            if (left == 0) break;
            idx  = lf[3:0];
            scan = 0;
         end else begin
            idx = idx + 4'd1;
            scan++;
            if (scan == 16) break;
         end
         lf = lfsr_nx(lf);
      end
      return b;
   endfunction

   function automatic int count_val(input board_t b, input int v);
      int n;
      n = 0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (b[r][c] == TILE_W'(v)) n++;
      return n;
   endfunction

   function automatic board_t mk1(input int r, input int c, input int v);
      board_t b;
      b = '0;
      b[r][c] = TILE_W'(v);
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_board(input string name, input board_t act, input board_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] dir;
      logic       use_cur;
      board_t     mb;
      logic       exp_chg;
      logic       exp_won;
      logic       exp_lost;
   } vec_t;

   vec_t   vecs[6];
   board_t full_b;

   task automatic do_init(input string tag);
      logic [15:0] le;
      board_t      exp_b;
      int          cyc;
      init = 1'b1;
      @(posedge clk); #1;
      init = 1'b0;
      le = m_lfsr;
      chk({tag, "_busy"}, busy, 1);
      cyc = 1;
      while (busy && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency_in_2_34"}, (cyc >= 2 && cyc <= 34), 1);
      exp_b   = spawn_model('0, le, SEED, 2);
      m_board = exp_b;
      chk_board({tag, "_board"}, board, exp_b);
      chk({tag, "_count_twos"}, count_val(board, 2), 2);
      chk({tag, "_won"}, won, 0);
      chk({tag, "_lost"}, lost, 0);
      chk({tag, "_ready"}, move_ready, 1);
   endtask

   task automatic do_move(input vec_t v, input int vi);
      board_t      mb;
      board_t      exp_b;
      logic [15:0] le;
      int          chg_cnt;
      int          cyc;
      string       t;
      t  = $sformatf("v%0d", vi);
      mb = v.use_cur ? m_board : v.mb;
      moved_board = mb;
      move_dir    = v.dir;
      move_valid  = 1'b1;
      @(posedge clk); #1;
      move_valid = 1'b0;
      chk({t, "_settle_sel"}, sel, v.dir);
      chk({t, "_settle_busy"}, busy, 1);
      chk({t, "_settle_ready"}, move_ready, 0);
      @(posedge clk); #1;
      le = m_lfsr;
      chk({t, "_compare_changed"}, changed, 0);
      chg_cnt = 0;
      cyc     = 0;
      while (busy && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (changed) chg_cnt++;
      end
      chk({t, "_back_idle"}, busy, 0);
      exp_b   = (mb != m_board) ? spawn_model(mb, le, lfsr_nx(le), 1) : m_board;
      m_board = exp_b;
      chk({t, "_changed_pulses"}, chg_cnt, v.exp_chg);
      chk_board({t, "_board"}, board, exp_b);
      chk({t, "_won"}, won, v.exp_won);
      chk({t, "_lost"}, lost, v.exp_lost);
      chk({t, "_sel_held"}, sel, v.dir);
      if (!v.exp_chg) chk({t, "_nochange_latency"}, cyc, 1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         full_b[i / 4][i % 4] = TILE_W'(2 << (i % 10));

      vecs[0] = '{dir: DIR_LEFT,  use_cur: 1'b0, mb: mk1(0, 3, 2),    exp_chg: 1'b1, exp_won: 1'b0, exp_lost: 1'b0};
      vecs[1] = '{dir: DIR_UP,    use_cur: 1'b0, mb: mk1(0, 0, 4),    exp_chg: 1'b1, exp_won: 1'b0, exp_lost: 1'b0};
      vecs[2] = '{dir: DIR_DOWN,  use_cur: 1'b0, mb: full_b,          exp_chg: 1'b1, exp_won: 1'b0, exp_lost: 1'b0};
      vecs[3] = '{dir: DIR_RIGHT, use_cur: 1'b1, mb: '0,              exp_chg: 1'b0, exp_won: 1'b0, exp_lost: 1'b1};
      vecs[4] = '{dir: DIR_UP,    use_cur: 1'b0, mb: mk1(1, 1, 2048), exp_chg: 1'b1, exp_won: 1'b1, exp_lost: 1'b1};
      vecs[5] = '{dir: DIR_LEFT,  use_cur: 1'b0, mb: mk1(3, 3, 8),    exp_chg: 1'b1, exp_won: 1'b1, exp_lost: 1'b1};

      rst         = 1'b1;
      init        = 1'b0;
      move_valid  = 1'b0;
      move_dir    = 2'd0;
      moved_board = '0;
      m_board     = '0;
      #12;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      chk_board("reset_board", board, '0);
      chk("reset_ready", move_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_sel", sel, 0);
      chk("reset_changed", changed, 0);
      chk("reset_won", won, 0);
      chk("reset_lost", lost, 0);

      do_init("init1");

      for (int i = 0; i < 6; i++)
         do_move(vecs[i], i);

      do_init("init2");

      // Full moved board keeps SPAWN busy for 16 scan cycles
      moved_board = full_b;
      move_dir    = DIR_DOWN;
      move_valid  = 1'b1;
      @(posedge clk); #1;
      move_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("spawn_changed", changed, 1);
      chk("spawn_busy", busy, 1);
      move_valid = 1'b1;
      move_dir   = DIR_RIGHT;
      chk("busy_ready_low", move_ready, 0);
      @(posedge clk); #1;
      chk("busy_sel_held", sel, DIR_DOWN);
      chk("busy_still_spawn", busy, 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      move_valid = 1'b0;
      chk_board("rst_spawn_board", board, '0);
      chk("rst_spawn_sel", sel, 0);
      chk("rst_spawn_changed", changed, 0);
      chk("rst_spawn_ready", move_ready, 1);
      chk("rst_spawn_busy", busy, 0);
      chk("rst_spawn_won", won, 0);
      chk("rst_spawn_lost", lost, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_board("post_rst_board", board, '0);
      chk("post_rst_ready", move_ready, 1);
      chk("post_rst_sel", sel, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
